// File: rtl/uart_pkg.sv
// Shared types and parity helper for the parametrised UART core.
// Latency: none; the package holds only types and a combinational function.
// Backpressure: not applicable; handshakes live in uart_core_param.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK_WAIT
    } rx_state_e;

    localparam int MAX_DATA_BITS = 9;

    // Callers zero-extend narrower data words; the extra zeros do not affect the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input parity_mode_e mode);
        logic p;
        p = ^data;
        case (mode)
            EVEN:    return p;
            ODD:     return ~p;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock tick every DIV clocks, free-running.
// Latency: first tick DIV clocks after reset release (every clock when DIV=1).
// Backpressure: none; the tick never stalls.
module uart_baud_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter wraps after DIV clocks; the tick marks the wrap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_core_param.sv
// Full-duplex UART: configurable width/parity/stop, 16x-style oversampled RX with majority vote.
// Latency: tx falls one clock after accept; rx_valid rises one clock after the mid-stop vote.
// Backpressure: tx_ready low while a frame is in flight; RX frames completing while an unconsumed frame is held are dropped with an rx_overrun pulse.
module uart_core_param import uart_pkg::*; #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun
);

    localparam int DIV        = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int BIT_PERIOD = DIV * OVERSAMPLE;
    localparam int TX_CW      = $clog2(BIT_PERIOD);
    localparam int RX_CW      = $clog2(OVERSAMPLE);
    localparam bit HAS_PARITY = (PARITY_MODE != 0);
    localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE[1:0]);

    localparam logic [TX_CW-1:0] TX_LAST   = TX_CW'(BIT_PERIOD - 1);
    localparam logic [RX_CW-1:0] RX_LAST   = RX_CW'(OVERSAMPLE - 1);
    localparam logic [RX_CW-1:0] VOTE_A    = RX_CW'(OVERSAMPLE / 2 - 1);
    localparam logic [RX_CW-1:0] VOTE_B    = RX_CW'(OVERSAMPLE / 2);
    localparam logic [RX_CW-1:0] VOTE_C    = RX_CW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_core_param: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_core_param: DATA_BITS must be 5..9");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
            $error("uart_core_param: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_core_param: STOP_BITS must be 1 or 2");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
            $error("uart_core_param: OVERSAMPLE must be even and >= 8");
        end
    endgenerate

    // ---------------- Transmitter ----------------
    tx_state_e            tx_state, tx_state_nxt;
    logic [TX_CW-1:0]     tx_cnt, tx_cnt_nxt;
    logic [3:0]           tx_idx, tx_idx_nxt;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_nxt;
    logic                 tx_par, tx_par_nxt, tx_nxt, tx_bit_end;

    assign tx_ready = (tx_state == TX_IDLE);

    // TX registers; tx itself is a flop so the pad never sees decode glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_shift <= tx_shift_nxt;
            tx_par   <= tx_par_nxt;
            tx       <= tx_nxt;
        end
    end

    // TX next state: each state visit lasts one bit period, counter restarted at accept.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_idx_nxt   = tx_idx;
        tx_shift_nxt = tx_shift;
        tx_par_nxt   = tx_par;
        tx_bit_end   = (tx_cnt == TX_LAST);
        tx_cnt_nxt   = tx_bit_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_nxt = '0;
                if (tx_valid) begin
                    tx_state_nxt = TX_START;
                    tx_shift_nxt = tx_data;
                    tx_par_nxt   = calc_parity(MAX_DATA_BITS'(tx_data), PMODE);
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_DATA;
                    tx_idx_nxt   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_nxt = tx_shift >> 1;
                    if (tx_idx == DATA_LAST) begin
                        tx_idx_nxt   = '0;
                        tx_state_nxt = HAS_PARITY ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_idx_nxt = tx_idx + 1'b1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_idx == STOP_LAST) tx_state_nxt = TX_IDLE;
                    else                     tx_idx_nxt   = tx_idx + 1'b1;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
        case (tx_state_nxt)
            TX_START:  tx_nxt = 1'b0;
            TX_DATA:   tx_nxt = tx_shift_nxt[0];
            TX_PARITY: tx_nxt = tx_par_nxt;
            default:   tx_nxt = 1'b1;
        endcase
    end

    // ---------------- Receiver ----------------
    logic                 rx_meta, rx_sync, rx_tick;
    rx_state_e            rx_state, rx_state_nxt;
    logic [RX_CW-1:0]     rx_cnt, rx_cnt_nxt;
    logic [1:0]           rx_samp, rx_samp_nxt;
    logic [3:0]           rx_idx, rx_idx_nxt;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_nxt;
    logic                 rx_par, rx_par_nxt;
    logic                 vote, vote_pt, bit_end;
    logic                 done_vld, done_par_err, done_frame_err, done_break;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .tick (rx_tick)
    );

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // RX FSM registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_samp  <= 2'b11;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_samp  <= rx_samp_nxt;
            rx_idx   <= rx_idx_nxt;
            rx_shift <= rx_shift_nxt;
            rx_par   <= rx_par_nxt;
        end
    end

    // RX next state: two mid-bit samples are stored, the third arrives live and decides the vote.
    always_comb begin
        rx_state_nxt   = rx_state;
        rx_cnt_nxt     = rx_cnt;
        rx_samp_nxt    = rx_samp;
        rx_idx_nxt     = rx_idx;
        rx_shift_nxt   = rx_shift;
        rx_par_nxt     = rx_par;
        done_vld       = 1'b0;
        done_par_err   = 1'b0;
        done_frame_err = 1'b0;
        done_break     = 1'b0;
        vote    = (rx_samp[1] & rx_samp[0]) | (rx_samp[1] & rx_sync) | (rx_samp[0] & rx_sync);
        vote_pt = rx_tick && (rx_cnt == VOTE_C);
        bit_end = rx_tick && (rx_cnt == RX_LAST);
        if (rx_tick && (rx_cnt == VOTE_A || rx_cnt == VOTE_B))
            rx_samp_nxt = {rx_samp[0], rx_sync};
        if (rx_tick && rx_state != RX_IDLE && rx_state != RX_BREAK_WAIT)
            rx_cnt_nxt = bit_end ? '0 : rx_cnt + 1'b1;
        case (rx_state)
            RX_IDLE: begin
                if (rx_tick && !rx_sync) begin
                    rx_state_nxt = RX_START;
                    rx_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (vote_pt && vote) rx_state_nxt = RX_IDLE;
                else if (bit_end) begin
                    rx_state_nxt = RX_DATA;
                    rx_idx_nxt   = '0;
                end
            end
            RX_DATA: begin
                if (vote_pt) rx_shift_nxt = {vote, rx_shift[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (rx_idx == DATA_LAST) rx_state_nxt = HAS_PARITY ? RX_PARITY : RX_STOP;
                    else                     rx_idx_nxt   = rx_idx + 1'b1;
                end
            end
            RX_PARITY: begin
                if (vote_pt) rx_par_nxt = vote;
                if (bit_end) rx_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (vote_pt) begin
                    done_vld       = 1'b1;
                    done_par_err   = HAS_PARITY &&
                                     (rx_par != calc_parity(MAX_DATA_BITS'(rx_shift), PMODE));
                    done_frame_err = !vote;
                    done_break     = (rx_shift == '0) && (!HAS_PARITY || !rx_par) && !vote;
                    rx_cnt_nxt     = '0;
                    rx_state_nxt   = done_break ? RX_BREAK_WAIT : RX_IDLE;
                end
            end
            RX_BREAK_WAIT: begin
                if (rx_tick) begin
                    if (!rx_sync) rx_cnt_nxt = '0;
                    else if (rx_cnt == RX_LAST) begin
                        rx_cnt_nxt   = '0;
                        rx_state_nxt = RX_IDLE;
                    end else rx_cnt_nxt = rx_cnt + 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // Output holding register: a completed frame loads only if the slot is free or being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= done_vld && rx_valid && !rx_ready;
            if (done_vld && (!rx_valid || rx_ready)) begin
                rx_data       <= rx_shift;
                rx_parity_err <= done_par_err;
                rx_frame_err  <= done_frame_err;
                rx_break      <= done_break;
                rx_valid      <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
module tb_uart_core_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int ovr_cnt = 0;

    // Instance A: 8E2, transmit only
    logic [7:0] a_tx_data, a_rx_data;
    logic a_tx_valid, a_tx_ready, a_tx, a_rx_valid, a_pe, a_fe, a_brk, a_ovr;
    logic a_rx = 1'b1, a_rx_ready = 1'b1;
    // Instance B: 7O1, tx looped back into rx
    logic [6:0] b_tx_data, b_rx_data;
    logic b_tx_valid, b_tx_ready, b_tx, b_rx_valid, b_pe, b_fe, b_brk, b_ovr;
    logic b_rx_ready = 1'b1;
    // Instance C: 8E1, rx driven directly by the bench
    logic [7:0] c_tx_data, c_rx_data;
    logic c_tx_valid, c_tx_ready, c_tx, c_rx_valid, c_pe, c_fe, c_brk, c_ovr;
    logic c_rx, c_rx_ready;

    logic [6:0] exp7 [3] = '{7'h00, 7'h7F, 7'h55};
    int acc [3];

    uart_core_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                      .PARITY_MODE(1), .STOP_BITS(2), .OVERSAMPLE(16)) u_a (
        .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
        .rx_parity_err(a_pe), .rx_frame_err(a_fe), .rx_break(a_brk), .rx_overrun(a_ovr));

    uart_core_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                      .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(16)) u_b (
        .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx(b_tx), .rx(b_tx), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
        .rx_parity_err(b_pe), .rx_frame_err(b_fe), .rx_break(b_brk), .rx_overrun(b_ovr));

    uart_core_param #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                      .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_c (
        .clk(clk), .rst(rst), .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ready(c_tx_ready),
        .tx(c_tx), .rx(c_rx), .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(c_rx_ready),
        .rx_parity_err(c_pe), .rx_frame_err(c_fe), .rx_break(c_brk), .rx_overrun(c_ovr));

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (c_ovr) ovr_cnt <= ovr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one 8E1 frame on c_rx, 16 clocks per bit, optionally inverting one clock
    task automatic inject(input logic [7:0] d, input logic par, input int glitch_at);
        logic [10:0] f;
        f = {1'b1, par, d, 1'b0};
        for (int c = 0; c < 176; c++) begin
            c_rx = f[c / 16] ^ (c == glitch_at);
            @(negedge clk);
        end
        c_rx = 1'b1;
    endtask

    task automatic consume(input string tag);
        c_rx_ready = 1'b1;
        @(negedge clk);
        c_rx_ready = 1'b0;
        check(tag, c_rx_valid, 1'b0);
    endtask

    initial begin
        logic [11:0] f8e2;
        int ovr0;
        a_tx_data = '0; a_tx_valid = 1'b0;
        b_tx_data = '0; b_tx_valid = 1'b0;
        c_tx_data = '0; c_tx_valid = 1'b0;
        c_rx = 1'b1; c_rx_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_a_tx", a_tx, 1'b1);
        check("rst_a_tx_ready", a_tx_ready, 1'b1);
        check("rst_b_tx", b_tx, 1'b1);
        check("rst_c_rx_valid", c_rx_valid, 1'b0);
        check("rst_c_rx_data", c_rx_data, 8'h00);
        check("rst_c_pe", c_pe, 1'b0);
        check("rst_c_fe", c_fe, 1'b0);
        check("rst_c_brk", c_brk, 1'b0);
        check("rst_c_ovr", c_ovr, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 8E2 transmit of 0xA5; busy-time tx_valid must be ignored
        f8e2 = {2'b11, 1'b0, 8'hA5, 1'b0};
        a_tx_data = 8'hA5; a_tx_valid = 1'b1;
        @(negedge clk);
        for (int c = 0; c <= 192; c++) begin
            if (c < 192) begin
                check("t1_tx_bit", a_tx, f8e2[c / 16]);
                check("t1_busy", a_tx_ready, 1'b0);
            end else begin
                check("t1_tx_idle", a_tx, 1'b1);
                check("t1_ready_at_193", a_tx_ready, 1'b1);
            end
            if (c == 0) a_tx_data = 8'hFF;
            if (c == 100) a_tx_valid = 1'b0;
            @(negedge clk);
        end

        // 2: 7O1 loopback, back-to-back frames
        fork
            begin
                b_tx_data = exp7[0]; b_tx_valid = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    int m;
                    m = 0;
                    while (!b_tx_ready && m < 400) begin @(negedge clk); m++; end
                    check("t2_tx_ready", b_tx_ready, 1'b1);
                    acc[i] = cyc;
                    @(negedge clk);
                    if (i < 2) b_tx_data = exp7[i + 1];
                    else       b_tx_valid = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    int n;
                    n = 0;
                    while (!b_rx_valid && n < 800) begin @(negedge clk); n++; end
                    check("t2_rx_valid", b_rx_valid, 1'b1);
                    check("t2_rx_data", b_rx_data, exp7[k]);
                    check("t2_pe", b_pe, 1'b0);
                    check("t2_fe", b_fe, 1'b0);
                    check("t2_brk", b_brk, 1'b0);
                    @(negedge clk);
                end
            end
        join
        check("t2_gap_0_1", acc[1] - acc[0], 161);
        check("t2_gap_1_2", acc[2] - acc[1], 161);

        // 3: 8E1 0xA5 with wrong parity bit
        inject(8'hA5, 1'b1, -1);
        check("t3_valid", c_rx_valid, 1'b1);
        check("t3_data", c_rx_data, 8'hA5);
        check("t3_pe", c_pe, 1'b1);
        check("t3_fe", c_fe, 1'b0);
        consume("t3_consumed");

        // 4a: short low pulse is a false start
        c_rx = 1'b0;
        repeat (4) @(negedge clk);
        c_rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_no_frame", c_rx_valid, 1'b0);

        // 4b: single-clock glitch in data bit 3 of 0x00, at the middle vote sample
        inject(8'h00, 1'b0, 16 * 4 + 9);
        check("t4_valid", c_rx_valid, 1'b1);
        check("t4_data", c_rx_data, 8'h00);
        check("t4_pe", c_pe, 1'b0);
        check("t4_brk", c_brk, 1'b0);
        consume("t4_consumed");

        // 5: break, 20 bit periods low
        ovr0 = ovr_cnt;
        c_rx = 1'b0;
        repeat (320) @(negedge clk);
        c_rx = 1'b1;
        check("t5_valid", c_rx_valid, 1'b1);
        check("t5_data", c_rx_data, 8'h00);
        check("t5_brk", c_brk, 1'b1);
        check("t5_fe", c_fe, 1'b1);
        check("t5_pe", c_pe, 1'b0);
        check("t5_single_frame", ovr_cnt - ovr0, 0);
        consume("t5_consumed");
        repeat (48) @(negedge clk);
        check("t5_quiet_after", c_rx_valid, 1'b0);
        inject(8'h3C, 1'b0, -1);
        check("t5_rearm_data", c_rx_data, 8'h3C);
        check("t5_rearm_brk", c_brk, 1'b0);
        consume("t5_rearm_consumed");

        // 6: overrun while held
        ovr0 = ovr_cnt;
        inject(8'h11, 1'b0, -1);
        inject(8'h22, 1'b0, -1);
        check("t6_overrun_once", ovr_cnt - ovr0, 1);
        check("t6_held_valid", c_rx_valid, 1'b1);
        check("t6_held_data", c_rx_data, 8'h11);
        consume("t6_consumed");

        // 6b: reset mid-frame with a held RX frame and a TX frame in flight
        inject(8'h5A, 1'b0, -1);
        check("t6_pre_valid", c_rx_valid, 1'b1);
        c_tx_data = 8'h00; c_tx_valid = 1'b1;
        @(negedge clk);
        c_tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_tx_busy", c_tx, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_tx", c_tx, 1'b1);
        check("t6_rst_tx_ready", c_tx_ready, 1'b1);
        check("t6_rst_rx_valid", c_rx_valid, 1'b0);
        check("t6_rst_rx_data", c_rx_data, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Full-duplex UART core, parametrised successor of the single-config driver. Configurable data width (5-9), parity mode (none/even/odd) and stop bits (1/2).
- Receiver: 16x-oversampled with 3-sample majority vote.
- Both directions use valid/ready handshakes.
- Reports framing, parity, break and overrun errors.
- Sits between the system bus/register block and the pads.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD_RATE, 115_200, line rate in bit/s.
- DATA_BITS, 8, data bits per frame; legal 5..9.
- PARITY_MODE, 0, 0=none, 1=even, 2=odd; parity generated and checked internally.
- STOP_BITS, 1, 1 or 2; TX sends this many; RX checks the first only.
- OVERSAMPLE, 16, RX samples per bit; even, >=8.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmitter idle; accepts when tx_valid&&tx_ready
- tx  out  1  serial out, idle high
- rx  in  1  serial in, asynchronous
- rx_data  out  DATA_BITS  received data, LSB first on wire
- rx_valid  out  1  rx_data/flags valid; held until consumed
- rx_ready  in  1  consumer accepts rx_data
- rx_parity_err  out  1  parity mismatch for the held frame
- rx_frame_err  out  1  first stop bit sampled low for the held frame
- rx_break  out  1  held frame was all-zero including parity and stop
- rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid high and rx_ready low; that frame is dropped

Behaviour:
- Constants:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE).
  - DIV<1 is an elaboration error, as are illegal DATA_BITS, PARITY_MODE or STOP_BITS values.
  - Bit period = DIV*OVERSAMPLE clocks.
- Reset values:
  - tx=1, tx_ready=1, rx_valid=0.
  - rx_data=0, all error flags 0, rx_overrun=0.
  - Sync flops=1, both FSMs idle.
  - Reset mid-frame aborts immediately; tx returns high asynchronously.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if none) -> STOP -> IDLE.
  - On accept, tx_data is captured and tx_ready drops the next cycle.
  - tx goes low the cycle after accept.
  - The TX bit counter restarts at accept, so every bit lasts exactly one bit period.
  - Parity: even = XOR of data; odd = inverted XOR.
  - tx_ready rises the cycle after the last stop bit ends.
  - Back-to-back accept in that cycle is legal: no idle gap.
  - tx_valid while not ready is ignored; tx_data is not captured.
- RX synchroniser: 2-flop synchroniser. An oversample tick fires every DIV clocks (free-running).
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> (BREAK_WAIT) -> IDLE.
  - IDLE: a synced low sample on a tick enters START with the tick counter at 0.
  - Majority vote: each bit value = majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - START: a voted 1 is treated as a glitch and returns to IDLE with no output.
  - DATA: shifts LSB first for DATA_BITS bits.
  - STOP: frame completes at the mid-stop vote.
- Frame completion:
  - Load rx_data and flags, set rx_valid.
  - If the frame is all zero and the stop bit is low, set rx_break and rx_frame_err, then go to BREAK_WAIT until the line is high for one full bit period, then IDLE.
- RX output handshake:
  - rx_valid cleared on rx_valid&&rx_ready.
  - Completion in the same cycle as consumption loads the new frame with no overrun.
  - Completion while held and not consumed: pulse rx_overrun, keep the old data.
- Second stop bit is not checked; the receiver re-arms after the first stop vote.
- TX and RX are fully independent; simultaneous operation is required.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_e (NONE, EVEN, ODD)
  - tx_state_e and rx_state_e
  - function calc_parity(data, mode)
- Sub-module uart_baud_gen: parametrised DIV counter producing the oversample tick.
- The TX bit-period counter and the RX sampling logic stay in the top level.

Test Plan:
Common config: CLK_FREQ=16_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16, so DIV=1 and bit period=16 clocks.
1. Config 8E2, send 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1 then parity 0, then 1,1; frame = 192 clocks; tx_ready high again at accept+193.
2. Config 7O1, loopback tx->rx of 0x00, 0x7F and 0x55 back-to-back -> three rx_valid with matching data, no error flags; tx has no idle gap between frames.
3. Config 8E1, inject 0xA5 with parity bit 1 -> rx_data=0xA5, rx_parity_err=1, rx_frame_err=0.
4. rx low for 4 clocks, then high -> no rx_valid and FSM back in IDLE. Separately, a 1-sample glitch inside data bit 3 of 0x00 -> rx_data=0x00 (majority vote).
5. rx held low for 20 bit periods, then high -> one frame: rx_data=0, rx_break=1, rx_frame_err=1; no further rx_valid until the line has been high for one full bit period.
6. rx_ready=0 while two frames 0x11 and 0x22 arrive -> rx_data stays 0x11 and rx_overrun pulses once. Assert rst mid-frame -> tx=1 and rx_valid=0 immediately.
